// File: rtl/adder_tree_sched.sv
// Round-robin scheduled packet accumulator: one requester owns the adder tree
// from grant to packet end, and its summed beats come out as a single result.
module adder_tree_sched #(
    parameter int ADDER_WIDTH = 4,
    parameter int NUM_REQ     = 4,
    parameter int ACC_WIDTH   = 8,
    parameter int MAX_BEATS   = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0]                   req_last,
    input  logic [NUM_REQ*4*ADDER_WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [ACC_WIDTH-1:0]                 res_sum,
    output logic [$clog2(NUM_REQ)-1:0]           res_id,
    output logic [$clog2(MAX_BEATS):0]           res_beats,
    output logic                                 res_ovf,
    output logic                                 res_trunc,
    output logic                                 busy
);

    localparam int W      = ADDER_WIDTH;
    localparam int N      = NUM_REQ;
    localparam int A      = ACC_WIDTH;
    localparam int M      = MAX_BEATS;
    localparam int ID_W   = $clog2(N);
    localparam int BEAT_W = $clog2(M) + 1;
    localparam int SUM_W  = W + 2;
    localparam int FULL_W = A + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   last_owner;
    logic [A-1:0]      acc;
    logic [BEAT_W-1:0] beats;
    logic              ovf;
    logic              trunc;

    logic              any_valid;
    logic [ID_W-1:0]   grant;
    logic [ID_W-1:0]   cand;

    logic [4*W-1:0]    owner_ops;
    logic [W:0]        pair_lo;
    logic [W:0]        pair_hi;
    logic [SUM_W-1:0]  beat_sum;
    logic [FULL_W-1:0] acc_full;
    logic [BEAT_W-1:0] beats_next;
    logic              beat_accept;
    logic              owner_last;
    logic              hit_max;

    // Search upward from the requester after the last owner, so the first hit wins.
    always_comb begin
        any_valid = |req_valid;
        grant     = last_owner;
        cand      = '0;
        for (int i = N; i >= 1; i--) begin
            cand = ID_W'((int'(last_owner) + i) % N);
            if (req_valid[cand]) begin
                grant = cand;
            end
        end
    end

    // Two-level tree over the owner's four operands, widened so no carry is lost.
    assign owner_ops   = req_data[owner*4*W +: 4*W];
    assign pair_lo     = {1'b0, owner_ops[0 +: W]}   + {1'b0, owner_ops[W +: W]};
    assign pair_hi     = {1'b0, owner_ops[2*W +: W]} + {1'b0, owner_ops[3*W +: W]};
    assign beat_sum    = {1'b0, pair_lo} + {1'b0, pair_hi};
    assign acc_full    = {1'b0, acc} + FULL_W'(beat_sum);

    assign beat_accept = (state == ACCUM) && req_valid[owner];
    assign owner_last  = req_last[owner];
    assign beats_next  = beats + BEAT_W'(1);
    assign hit_max     = (beats_next == BEAT_W'(M));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (beat_accept && (owner_last || hit_max)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state == ACCUM) begin
            req_ready[owner] = 1'b1;
        end
        res_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // The grant cycle doubles as packet setup; result registers stay put through DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner      <= '0;
            last_owner <= ID_W'(N - 1);
            acc        <= '0;
            beats      <= '0;
            ovf        <= 1'b0;
            trunc      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        owner <= grant;
                        acc   <= '0;
                        beats <= '0;
                        ovf   <= 1'b0;
                        trunc <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (beat_accept) begin
                        acc   <= acc_full[A-1:0];
                        beats <= beats_next;
                        if (acc_full[A]) begin
                            ovf <= 1'b1;
                        end
                        if (hit_max && !owner_last) begin
                            trunc <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        last_owner <= owner;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_sum   = acc;
    assign res_id    = owner;
    assign res_beats = beats;
    assign res_ovf   = ovf;
    assign res_trunc = trunc;

endmodule

// File: tb/tb_adder_tree_sched.sv
// Bench for adder_tree_sched: directed protocol scenarios plus randomized packet
// traffic scored against a packet-level round-robin model.
module tb_adder_tree_sched;

    localparam int W   = 4;
    localparam int N   = 4;
    localparam int A   = 8;
    localparam int M   = 16;
    localparam int IDW = 2;
    localparam int BW  = 5;
    localparam int QD  = 256;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_last;
    logic [N*16-1:0]  req_data;
    logic [N-1:0]     req_ready;
    logic             res_valid;
    logic             res_ready;
    logic [A-1:0]     res_sum;
    logic [IDW-1:0]   res_id;
    logic [BW-1:0]    res_beats;
    logic             res_ovf;
    logic             res_trunc;
    logic             busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int sum;
        int id;
        int beats;
        int ovf;
        int trunc;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] qd[N][QD];
    logic        ql[N][QD];
    int          qh[N];
    int          qn[N];
    int          pkt_cnt[N];

    always #5 clk = ~clk;

    adder_tree_sched #(
        .ADDER_WIDTH(W),
        .NUM_REQ(N),
        .ACC_WIDTH(A),
        .MAX_BEATS(M)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_last(req_last),
        .req_data(req_data),
        .req_ready(req_ready),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_sum(res_sum),
        .res_id(res_id),
        .res_beats(res_beats),
        .res_ovf(res_ovf),
        .res_trunc(res_trunc),
        .busy(busy)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] l,
                                 input logic [N*16-1:0] d, input logic rdy);
        req_valid = v;
        req_last  = l;
        req_data  = d;
        res_ready = rdy;
    endtask

    function automatic logic [15:0] ops(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus('0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state",
                    32'({res_valid, req_ready, busy, res_sum, res_id, res_beats, res_ovf, res_trunc}), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clearQueues();
        for (int r = 0; r < N; r++) begin
            qh[r]      = 0;
            qn[r]      = 0;
            pkt_cnt[r] = 0;
        end
        expq.delete();
    endtask

    task automatic pushBeat(input int r, input logic [15:0] d, input logic l);
        qd[r][qn[r]] = d;
        ql[r][qn[r]] = l;
        qn[r]++;
    endtask

    // Packet-level model: grant the next non-empty queue after the previous owner,
    // then cut its beats at a last flag or after M beats.
    task automatic buildModel();
        int ph[N];
        int last_o, owner, c, total, cnt;
        bit fin, tr;
        logic [15:0] d;
        exp_t e;
        for (int r = 0; r < N; r++) ph[r] = qh[r];
        last_o = N - 1;
        while (1) begin
            owner = -1;
            for (int i = 1; i <= N; i++) begin
                c = (last_o + i) % N;
                if (owner < 0 && ph[c] < qn[c]) owner = c;
            end
            if (owner < 0) break;
            total = 0; cnt = 0; fin = 0; tr = 0;
            while (!fin) begin
                d = qd[owner][ph[owner]];
                total += int'(d[3:0]) + int'(d[7:4]) + int'(d[11:8]) + int'(d[15:12]);
                cnt++;
                fin = ql[owner][ph[owner]];
                ph[owner]++;
                if (!fin && cnt == M) begin
                    tr  = 1;
                    fin = 1;
                end
                if (ph[owner] >= qn[owner]) fin = 1;
            end
            e.sum   = total % (1 << A);
            e.id    = owner;
            e.beats = cnt;
            e.ovf   = (total >= (1 << A)) ? 1 : 0;
            e.trunc = tr ? 1 : 0;
            expq.push_back(e);
            last_o = owner;
        end
    endtask

    // Mid-packet requesters may drop valid; waiting requesters hold it so arbitration stays predictable.
    task automatic driveHeads();
        logic [N-1:0]    v;
        logic [N-1:0]    l;
        logic [N*16-1:0] d;
        v = '0; l = '0; d = '0;
        for (int r = 0; r < N; r++) begin
            if (qh[r] < qn[r]) begin
                v[r]           = !(pkt_cnt[r] > 0 && $urandom_range(0, 3) == 0);
                d[r*16 +: 16]  = qd[r][qh[r]];
                l[r]           = ql[r][qh[r]];
            end
        end
        applyStimulus(v, l, d, $urandom_range(0, 2) != 0);
    endtask

    task automatic runEngine(input string name);
        int          cyc;
        int          viol;
        logic        hold;
        logic [31:0] prev_res;
        logic [31:0] cur_res;
        logic [N-1:0] acc_m;
        logic        hs;
        exp_t        e;
        buildModel();
        viol = 0; hold = 1'b0; prev_res = 0; cyc = 0;
        driveHeads();
        while (expq.size() > 0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            cur_res = 32'({res_sum, res_id, res_beats, res_ovf, res_trunc});
            if (!$onehot0(req_ready)) viol++;
            if (hold && (cur_res != prev_res || !res_valid)) viol++;
            hold     = res_valid && !res_ready;
            prev_res = cur_res;
            acc_m    = req_valid & req_ready;
            hs       = res_valid & res_ready;
            if (hs) begin
                e = expq.pop_front();
                checkOutput({name, "_sum"},   32'(res_sum),   e.sum);
                checkOutput({name, "_id"},    32'(res_id),    e.id);
                checkOutput({name, "_beats"}, 32'(res_beats), e.beats);
                checkOutput({name, "_ovf"},   32'(res_ovf),   e.ovf);
                checkOutput({name, "_trunc"}, 32'(res_trunc), e.trunc);
            end
            @(posedge clk);
            #1;
            for (int r = 0; r < N; r++) begin
                if (acc_m[r]) begin
                    pkt_cnt[r]++;
                    if (ql[r][qh[r]] || pkt_cnt[r] == M) pkt_cnt[r] = 0;
                    qh[r]++;
                end
            end
            driveHeads();
        end
        checkOutput({name, "_pending_results"}, 32'(expq.size()), 0);
        checkOutput({name, "_ready_onehot_hold"}, 32'(viol), 0);
        applyStimulus('0, '0, '0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput({name, "_no_extra_result"}, 32'(res_valid), 0);
        expq.delete();
    endtask

    initial begin
        logic [N*16-1:0] dv;
        int bad;
        int npk, len;

        doReset();

        // Single beat from requester 2
        dv = '0;
        dv[2*16 +: 16] = ops(1, 2, 3, 4);
        applyStimulus(4'b0100, 4'b0100, dv, 1'b1);
        @(negedge clk);
        checkOutput("t1_idle_no_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t1_ready_owner2", 32'(req_ready), 32'h4);
        checkOutput("t1_busy", 32'(busy), 1);
        checkOutput("t1_no_early_valid", 32'(res_valid), 0);
        @(posedge clk); #1;
        applyStimulus('0, '0, '0, 1'b1);
        @(negedge clk);
        checkOutput("t1_res_valid", 32'(res_valid), 1);
        checkOutput("t1_res_sum", 32'(res_sum), 10);
        checkOutput("t1_res_id", 32'(res_id), 2);
        checkOutput("t1_res_beats", 32'(res_beats), 1);
        checkOutput("t1_ovf_trunc", 32'({res_ovf, res_trunc}), 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t1_valid_drop", 32'(res_valid), 0);

        // Overflowing packet: 5 x 60
        doReset();
        clearQueues();
        for (int b = 0; b < 5; b++) pushBeat(0, ops(15, 15, 15, 15), b == 4);
        runEngine("t2_ovf");

        // Fair rotation with everybody valid
        doReset();
        clearQueues();
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < N; r++) pushBeat(r, ops(r, p, 1, 0), 1'b1);
        runEngine("t3_rotate");

        // Truncation at M beats, remainder forms a new packet
        doReset();
        clearQueues();
        for (int b = 0; b < 18; b++) pushBeat(1, ops(1, 0, 0, 0), b == 17);
        runEngine("t4_trunc");

        // Result held under back-pressure while requester 3 waits
        doReset();
        dv = '0;
        dv[0 +: 16]    = ops(5, 5, 5, 5);
        dv[3*16 +: 16] = ops(1, 1, 1, 1);
        applyStimulus(4'b1001, 4'b1001, dv, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t5_ready_owner0", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        applyStimulus(4'b1000, 4'b1001, dv, 1'b0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!res_valid || res_sum != 8'd20 || res_id != 2'd0 || res_beats != 5'd1 ||
                res_ovf || res_trunc || req_ready != '0) bad++;
            @(posedge clk); #1;
        end
        checkOutput("t5_hold_stable", 32'(bad), 0);
        res_ready = 1'b1;
        @(negedge clk);
        checkOutput("t5_still_valid", 32'(res_valid), 1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t5_idle_no_ready", 32'({res_valid, req_ready}), 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t5_ready_owner3", 32'(req_ready), 32'h8);
        @(posedge clk); #1;
        applyStimulus('0, '0, '0, 1'b1);
        @(negedge clk);
        checkOutput("t5_res_id3", 32'(res_id), 3);
        checkOutput("t5_res_sum4", 32'(res_sum), 4);
        @(posedge clk); #1;

        // Reset in the middle of a packet discards it
        doReset();
        dv = '0;
        dv[1*16 +: 16] = ops(2, 0, 0, 0);
        applyStimulus(4'b0010, 4'b0000, dv, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t6_no_valid_mid", 32'(res_valid), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dv[1*16 +: 16] = ops(3, 0, 0, 0);
        applyStimulus(4'b0010, 4'b0010, dv, 1'b1);
        @(negedge clk);
        checkOutput("t6_after_reset", 32'({res_valid, busy, res_sum}), 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        applyStimulus('0, '0, '0, 1'b1);
        @(negedge clk);
        checkOutput("t6_res_valid", 32'(res_valid), 1);
        checkOutput("t6_res_sum", 32'(res_sum), 3);
        checkOutput("t6_res_beats", 32'(res_beats), 1);
        checkOutput("t6_res_id", 32'(res_id), 1);
        @(posedge clk); #1;

        // Randomized traffic
        for (int round = 0; round < 4; round++) begin
            doReset();
            clearQueues();
            for (int r = 0; r < N; r++) begin
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 20);
                    for (int b = 0; b < len; b++) pushBeat(r, 16'($urandom), b == len - 1);
                end
            end
            runEngine("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_tree_sched.md
ADDER_TREE_SCHED -- requirements
Module: adder_tree_sched

Interface
REQ-001 Parameter ADDER_WIDTH, default 4, SHALL set the operand width W.
REQ-002 Parameter NUM_REQ, default 4, SHALL set the number of requesters N (2..8).
REQ-003 Parameter ACC_WIDTH, default 8, SHALL set the accumulator and result width A (A >= W+2).
REQ-004 Parameter MAX_BEATS, default 16, SHALL set the maximum beats per packet M (power of 2).
REQ-005 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-007 Port req_valid, input, N: per-requester beat valid.
REQ-008 Port req_last, input, N: per-requester last beat of packet.
REQ-009 Port req_data, input, N*4*W: four W-bit unsigned operands per requester; requester i occupies bits [i*4W +: 4W], operand k at [i*4W+k*W +: W].
REQ-010 Port req_ready, output, N: per-requester beat accept.
REQ-011 Port res_valid, input res_ready: output 1 and input 1, the result handshake.
REQ-012 Port res_sum, output, A: accumulated packet sum.
REQ-013 Port res_id, output, clog2(N): owner of the result.
REQ-014 Port res_beats, output, clog2(M)+1: beats accumulated.
REQ-015 Port res_ovf, output, 1: accumulator wrapped during packet; res_trunc, output, 1: packet cut at M beats.
REQ-016 Port busy, output, 1: high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ACCUM, DONE.
REQ-018 IDLE: if any req_valid is high, the block SHALL register owner = first valid requester searching upward (modulo N) from last_owner+1, then move to ACCUM; no beat is accepted in IDLE.
REQ-019 Entry into ACCUM SHALL clear acc, beat count, ovf and trunc.
REQ-020 ACCUM: req_ready SHALL be high only for owner; all other req_ready bits SHALL be 0 in every state.
REQ-021 A beat is accepted when req_valid[owner] and req_ready[owner] are both high; beat_sum = sum of the four operands at width W+2 (two-level tree, no loss).
REQ-022 Per accepted beat: acc <= (acc + beat_sum) mod 2^A; ovf set sticky if the true sum is >= 2^A; beat count +1.
REQ-023 ACCUM SHALL stay in place with no state change on cycles with no accepted beat.
REQ-024 Accepted beat with req_last high SHALL move to DONE; res_valid SHALL be high the following cycle (1-cycle latency from last beat).
REQ-025 Accepted beat that makes beat count equal M with req_last low SHALL move to DONE with res_trunc=1; following beats of that requester start a new packet.
REQ-026 DONE: res_valid=1; res_sum, res_id, res_beats, res_ovf, res_trunc SHALL hold stable until res_ready is high.
REQ-027 DONE with res_ready high: last_owner <= owner and next state IDLE; res_valid low the following cycle.
REQ-028 Owner lock: the owner keeps the grant from first beat to packet end regardless of other requests; no preemption.
REQ-029 Fairness: with all N requesters continuously valid, grants SHALL rotate 0,1,...,N-1,0.
REQ-030 req_data and req_last of non-owners SHALL have no effect on any state.

Reset
REQ-031 rst_n low at a clock edge SHALL force IDLE, acc=0, beat count=0, res_valid=0, req_ready=0, res_sum=0, res_id=0, res_beats=0, res_ovf=0, res_trunc=0, busy=0, last_owner=N-1 (requester 0 highest priority after reset).
REQ-032 Reset asserted mid-packet (ACCUM or DONE) SHALL discard the packet without producing a result.

Verification
REQ-033 Defaults; reset; requester 2 sends one beat {1,2,3,4} last=1, res_ready=1 -> req_ready[2] high 1 cycle after request, res_valid next cycle, res_sum=10, res_id=2, res_beats=1, ovf=0, trunc=0.
REQ-034 Requester 0 sends 5 beats {15,15,15,15} -> true sum 300, res_sum=44, res_ovf=1, res_beats=5.
REQ-035 All 4 requesters continuously valid, single-beat packets -> res_id sequence 0,1,2,3,0; req_ready never multi-hot.
REQ-036 Requester 1 holds valid, last=0 for 17 beats of {1,0,0,0} -> first result res_beats=16, res_sum=16, res_trunc=1; second packet begins on following beat.
REQ-037 res_ready held low 10 cycles in DONE while requester 3 valid -> result outputs stable, req_ready all 0, grant to 3 only after handshake.
REQ-038 rst_n pulsed low in ACCUM after 2 beats -> no res_valid; next packet result excludes the discarded beats.
